layer_requant: RTL and testbench

- Sits directly downstream of a `layer` instance and upstream of the next `layer`.
- Captures the wide signed row sums (2*datawidth bits per row) when the layer signals done.
- Processes rows serially through one shared unit: optional ReLU, round-half-up right shift by FRAC_BITS, saturation to datawidth bits.
- Presents the packed datawidth-bit vector as the next layer's `values`, with a one-cycle `next_en` pulse.

---
 rtl/layer_requant.sv | 94 +++++++++
 tb/tb_layer_requant.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_requant.sv
// Requantizes a layer's wide signed row sums into a packed datawidth-bit vector for the next layer.
// Rows go one per cycle through a shared ReLU / round-half-up shift / saturate unit.
module layer_requant #(
  parameter int rows      = 30,
  parameter int datawidth = 11,
  parameter int FRAC_BITS = 7,
  parameter int RELU_EN   = 1
) (
  input  logic                            clk,
  input  logic                            rst_overall,
  input  logic [rows*2*datawidth-1:0]     in_data,
  input  logic                            in_done,
  output logic [rows*datawidth-1:0]       out_values,
  output logic                            out_valid,
  output logic                            next_en,
  output logic                            busy,
  output logic                            overrun
);

  localparam int XW = 2 * datawidth;
  localparam int EW = XW + 1;
  localparam int CW = (rows > 1) ? $clog2(rows) : 1;

  localparam logic signed [EW-1:0] HALF = EW'((2 ** FRAC_BITS) / 2);
  localparam logic signed [EW-1:0] SMAX = EW'((2 ** (datawidth - 1)) - 1);
  localparam logic signed [EW-1:0] SMIN = -EW'(2 ** (datawidth - 1));

  typedef enum logic [1:0] {IDLE, PROC, EMIT} state_t;

  state_t                     r_state;
  logic [rows*XW-1:0]         r_cap;
  logic [rows*datawidth-1:0]  r_stage;
  logic [CW-1:0]              r_cnt;

  int                         w_row;
  logic signed [XW-1:0]       w_x;
  logic signed [EW-1:0]       w_ext;
  logic signed [EW-1:0]       w_t;
  logic [datawidth-1:0]       w_res;

  // Rows are packed MSB-first, so row idx lives at slot rows-1-idx.
  always_comb begin
    w_row = rows - 1 - int'(r_cnt);
    w_x   = r_cap[w_row*XW +: XW];
    if (RELU_EN != 0 && w_x < 0) w_x = '0;
    w_ext = {w_x[XW-1], w_x};
    w_t   = (w_ext + HALF) >>> FRAC_BITS;
    if (w_t > SMAX)      w_res = SMAX[datawidth-1:0];
    else if (w_t < SMIN) w_res = SMIN[datawidth-1:0];
    else                 w_res = w_t[datawidth-1:0];
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      r_state    <= IDLE;
      r_cap      <= '0;
      r_stage    <= '0;
      r_cnt      <= '0;
      out_values <= '0;
      out_valid  <= 1'b0;
      next_en    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      next_en <= 1'b0;
      if (in_done && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (in_done) begin
            r_cap     <= in_data;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            r_state   <= PROC;
          end
        end
        PROC: begin
          r_stage[w_row*datawidth +: datawidth] <= w_res;
          if (r_cnt == CW'(rows - 1)) r_state <= EMIT;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        EMIT: begin
          out_values <= r_stage;
          out_valid  <= 1'b1;
          next_en    <= 1'b1;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_requant.sv
// Bench for layer_requant: three parameterisations share stimulus; results checked against an integer model.
module tb_layer_requant;
  localparam int ROWS = 30;
  localparam int DW   = 11;
  localparam int XW   = 2 * DW;

  logic clk = 1'b0;
  logic rst;
  logic in_done;
  logic [ROWS*XW-1:0] in_data;

  logic [ROWS*DW-1:0] ov[3];
  logic vl[3], ne[3], bz[3], orun[3];

  bit relu_p[3] = '{1'b1, 1'b0, 1'b0};
  int frac_p[3] = '{7, 7, 0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  layer_requant #(.rows(ROWS), .datawidth(DW), .FRAC_BITS(7), .RELU_EN(1)) u_a (
    .clk(clk), .rst_overall(rst), .in_data(in_data), .in_done(in_done),
    .out_values(ov[0]), .out_valid(vl[0]), .next_en(ne[0]), .busy(bz[0]), .overrun(orun[0]));
  layer_requant #(.rows(ROWS), .datawidth(DW), .FRAC_BITS(7), .RELU_EN(0)) u_b (
    .clk(clk), .rst_overall(rst), .in_data(in_data), .in_done(in_done),
    .out_values(ov[1]), .out_valid(vl[1]), .next_en(ne[1]), .busy(bz[1]), .overrun(orun[1]));
  layer_requant #(.rows(ROWS), .datawidth(DW), .FRAC_BITS(0), .RELU_EN(0)) u_c (
    .clk(clk), .rst_overall(rst), .in_data(in_data), .in_done(in_done),
    .out_values(ov[2]), .out_valid(vl[2]), .next_en(ne[2]), .busy(bz[2]), .overrun(orun[2]));

  // Reference: ReLU, add half, floor-divide by 2^f, clamp to the signed DW range.
  function automatic longint rq(input longint x_in, input bit relu, input int f);
    longint x, d, n, t;
    x = x_in;
    if (relu && x < 0) x = 0;
    if (f == 0) t = x;
    else begin
      d = longint'(1) << f;
      n = x + d / 2;
      t = (n >= 0) ? n / d : -((-n + d - 1) / d);
    end
    if (t > (longint'(1) << (DW - 1)) - 1) t = (longint'(1) << (DW - 1)) - 1;
    if (t < -(longint'(1) << (DW - 1)))    t = -(longint'(1) << (DW - 1));
    return t;
  endfunction

  function automatic logic [ROWS*DW-1:0] exp_vec(input logic [ROWS*XW-1:0] d, input bit relu, input int f);
    logic [ROWS*DW-1:0] v;
    logic [XW-1:0] raw;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      raw = d[(ROWS-1-r)*XW +: XW];
      v[(ROWS-1-r)*DW +: DW] = DW'(rq(longint'($signed(raw)), relu, f));
    end
    return v;
  endfunction

  function automatic logic [ROWS*DW-1:0] mk3(input longint a, input longint b, input longint c);
    logic [ROWS*DW-1:0] v;
    v = '0;
    v[(ROWS-1)*DW +: DW] = DW'(a);
    v[(ROWS-2)*DW +: DW] = DW'(b);
    v[(ROWS-3)*DW +: DW] = DW'(c);
    return v;
  endfunction

  task automatic set3(input longint a, input longint b, input longint c);
    in_data = '0;
    in_data[(ROWS-1)*XW +: XW] = XW'(a);
    in_data[(ROWS-2)*XW +: XW] = XW'(b);
    in_data[(ROWS-3)*XW +: XW] = XW'(c);
  endtask

  task automatic set_random();
    longint v;
    longint ext[6] = '{2097151, -2097152, 131071, 131072, -131072, -131137};
    for (int r = 0; r < ROWS; r++) begin
      case ($urandom_range(0, 3))
        0: v = longint'($urandom_range(0, (1 << XW) - 1));
        1: v = longint'(int'($urandom_range(0, 1000)) - 500);
        2: v = longint'(int'($urandom_range(0, 200)) - 100) * 128 + 64 + longint'(int'($urandom_range(0, 2)) - 1);
        default: v = ext[$urandom_range(0, 5)];
      endcase
      in_data[(ROWS-1-r)*XW +: XW] = XW'(v);
    end
  endtask

  // One complete frame; inj>0 pulses in_done again at that PROC cycle.
  task automatic run_frame(input int inj, input string tag);
    logic [ROWS*DW-1:0] ex[3];
    int c, bcnt;
    for (int i = 0; i < 3; i++) ex[i] = exp_vec(in_data, relu_p[i], frac_p[i]);
    @(negedge clk) in_done = 1'b1;
    @(negedge clk) in_done = 1'b0;
    bcnt = (bz[0] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bz[i] !== 1'b1 || vl[i] !== 1'b0) begin
        n_err++;
        $display("FAIL %s capture inst%0d: busy=%b valid=%b, required busy=1 valid=0", tag, i, bz[i], vl[i]);
      end
    end
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      in_done = (inj > 0 && c == inj);
      if (bz[0] === 1'b1) bcnt++;
      if (ne[0] === 1'b1) break;
    end
    in_done = 1'b0;
    n_cmp++;
    if (c !== ROWS + 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, c, ROWS + 1);
    end
    n_cmp++;
    if (bcnt !== ROWS + 1) begin
      n_err++;
      $display("FAIL %s busy_len: got %0d cycles, required %0d", tag, bcnt, ROWS + 1);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ne[i] !== 1'b1 || vl[i] !== 1'b1) begin
        n_err++;
        $display("FAIL %s emit inst%0d: next_en=%b valid=%b, required 1 1", tag, i, ne[i], vl[i]);
      end
      n_cmp++;
      if (ov[i] !== ex[i]) begin
        n_err++;
        $display("FAIL %s values inst%0d: got %h required %h", tag, i, ov[i], ex[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ne[i] !== 1'b0 || bz[i] !== 1'b0 || vl[i] !== 1'b1 || ov[i] !== ex[i]) begin
        n_err++;
        $display("FAIL %s post inst%0d: next_en=%b busy=%b valid=%b, required 0 0 1 with values held",
                 tag, i, ne[i], bz[i], vl[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_done = 1'b0; in_data = '0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov[i] !== '0 || vl[i] !== 1'b0 || ne[i] !== 1'b0 || bz[i] !== 1'b0 || orun[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst%0d: vals=%h valid=%b next_en=%b busy=%b overrun=%b, required all 0",
                 i, ov[i], vl[i], ne[i], bz[i], orun[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    set3(1000, 192, -200);
    run_frame(0, "dir_relu");
    n_cmp++;
    if (ov[0] !== mk3(8, 2, 0)) begin
      n_err++; $display("FAIL dir_relu_const: got %h required %h", ov[0], mk3(8, 2, 0));
    end
    set3(-200, -64, -65);
    run_frame(0, "dir_signed");
    n_cmp++;
    if (ov[1] !== mk3(-2, 0, -1)) begin
      n_err++; $display("FAIL dir_signed_const: got %h required %h", ov[1], mk3(-2, 0, -1));
    end
    set3(2097151, -2097152, 131071);
    run_frame(0, "dir_sat");
    n_cmp++;
    if (ov[1] !== mk3(1023, -1024, 1023)) begin
      n_err++; $display("FAIL dir_sat_const: got %h required %h", ov[1], mk3(1023, -1024, 1023));
    end
    set3(500, 1500, -1500);
    run_frame(0, "dir_frac0");
    n_cmp++;
    if (ov[2] !== mk3(500, 1023, -1024)) begin
      n_err++; $display("FAIL dir_frac0_const: got %h required %h", ov[2], mk3(500, 1023, -1024));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      set_random();
      run_frame(0, "random");
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (orun[i] !== 1'b0) begin
        n_err++; $display("FAIL overrun_pre inst%0d: got %b required 0", i, orun[i]);
      end
    end
    set_random();
    run_frame(10, "overrun_first");
    set_random();
    run_frame(0, "overrun_second");
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (orun[i] !== 1'b1) begin
        n_err++; $display("FAIL overrun_sticky inst%0d: got %b required 1", i, orun[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ROWS*DW-1:0] ex1[3], ex2[3];
    int c, c2;
    set_random();
    for (int i = 0; i < 3; i++) ex1[i] = exp_vec(in_data, relu_p[i], frac_p[i]);
    @(negedge clk) in_done = 1'b1;
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        set_random();
        for (int i = 0; i < 3; i++) ex2[i] = exp_vec(in_data, relu_p[i], frac_p[i]);
      end
      if (ne[0] === 1'b1) break;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov[i] !== ex1[i]) begin
        n_err++; $display("FAIL b2b_first inst%0d: got %h required %h", i, ov[i], ex1[i]);
      end
    end
    c2 = 0;
    while (c2 < 100) begin
      @(negedge clk);
      c2++;
      if (ne[0] === 1'b1) break;
    end
    in_done = 1'b0;
    n_cmp++;
    if (c2 !== ROWS + 2) begin
      n_err++; $display("FAIL b2b_period: got %0d cycles, required %0d", c2, ROWS + 2);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov[i] !== ex2[i]) begin
        n_err++; $display("FAIL b2b_second inst%0d: got %h required %h", i, ov[i], ex2[i]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    set_random();
    @(negedge clk) in_done = 1'b1;
    @(negedge clk) in_done = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov[i] !== '0 || vl[i] !== 1'b0 || ne[i] !== 1'b0 || bz[i] !== 1'b0 || orun[i] !== 1'b0) begin
        n_err++;
        $display("FAIL midreset inst%0d: vals=%h valid=%b next_en=%b busy=%b overrun=%b, required all 0",
                 i, ov[i], vl[i], ne[i], bz[i], orun[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ne[0] === 1'b1 || ne[1] === 1'b1 || ne[2] === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL midreset_no_emit: got %0d next_en pulses, required 0", seen);
    end
    set_random();
    run_frame(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
